// File: rtl/dnn_pkg.sv
// Shared constants and types for the DNN classifier back end.
// The argmax stage builds its runner-up / margin logic only when the
// ARGMAX_MARGIN_EN macro is defined.
package dnn_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int NUM_CLASSES = 10;
   localparam int IDX_WIDTH   = 4;

   // Index of the final class scanned; the counter stops here, so it never wraps.
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

   // Most negative signed score, used to seed the runner-up.
   localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational top-2 update for the argmax scan.
// Given the current score and index, returns the next best, best index and
// (with ARGMAX_MARGIN_EN) runner-up. Ties keep the earlier (lower) index.
module argmax_cmp
   import dnn_pkg::*;
(
   input  logic signed [DATA_WIDTH-1:0] score,
   input  logic        [IDX_WIDTH-1:0]  idx,
   input  logic signed [DATA_WIDTH-1:0] best,
   input  logic        [IDX_WIDTH-1:0]  best_idx,
`ifdef ARGMAX_MARGIN_EN
   input  logic signed [DATA_WIDTH-1:0] second,
   output logic signed [DATA_WIDTH-1:0] next_second,
`endif
   input  logic                         first,
   output logic signed [DATA_WIDTH-1:0] next_best,
   output logic        [IDX_WIDTH-1:0]  next_best_idx
);

   // Select the updated top-2 for this score.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      next_best     = best;
      next_best_idx = best_idx;
`ifdef ARGMAX_MARGIN_EN
      next_second   = second;
`endif
      if (first) begin
         next_best     = score;
         next_best_idx = idx;
`ifdef ARGMAX_MARGIN_EN
         next_second   = SCORE_MIN;
`endif
      end else if (score > best) begin
`ifdef ARGMAX_MARGIN_EN
         next_second   = best;
`endif
         next_best     = score;
         next_best_idx = idx;
      end
`ifdef ARGMAX_MARGIN_EN
      else if (score > second) begin
         next_second   = score;
      end
`endif
   end

endmodule

// File: rtl/dnn_argmax_seq.sv
// Sequential argmax over the inference top's class scores.
// A rising edge of done scans NUM_CLASSES scores through out_idx/score, one per
// cycle, then holds the winning digit and score with valid set.
// ARGMAX_MARGIN_EN adds runner-up tracking and drives margin; otherwise margin is 0.
module dnn_argmax_seq
   import dnn_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         done,
   input  logic                         clear,
   output logic        [IDX_WIDTH-1:0]  out_idx,
   input  logic signed [DATA_WIDTH-1:0] score,
   output logic        [IDX_WIDTH-1:0]  digit,
   output logic signed [DATA_WIDTH-1:0] max_score,
   output logic        [DATA_WIDTH:0]   margin,
   output logic                         busy,
   output logic                         valid
);

   argmax_state_t                 state;
   logic        [IDX_WIDTH-1:0]   idx;
   logic                          done_q;
   logic                          wait_low;
   logic                          start;
   logic signed [DATA_WIDTH-1:0]  best;
   logic        [IDX_WIDTH-1:0]   best_idx;
   logic signed [DATA_WIDTH-1:0]  next_best;
   logic        [IDX_WIDTH-1:0]   next_best_idx;
`ifdef ARGMAX_MARGIN_EN
   logic signed [DATA_WIDTH-1:0]  second;
   logic signed [DATA_WIDTH-1:0]  next_second;
   logic        [DATA_WIDTH:0]    margin_q;
`endif

   // wait_low blocks a start until done has been seen low after reset, so a
   // done level that survives reset is not mistaken for a new completion.
   assign start   = done & ~done_q & ~wait_low;
   assign busy    = (state == SCAN);
   assign out_idx = idx;   // idx is held at 0 outside SCAN

`ifdef ARGMAX_MARGIN_EN
   assign margin = margin_q;
`else
   assign margin = '0;
`endif

   argmax_cmp u_cmp (
      .score         (score),
      .idx           (idx),
      .best          (best),
      .best_idx      (best_idx),
`ifdef ARGMAX_MARGIN_EN
      .second        (second),
      .next_second   (next_second),
`endif
      .first         (idx == '0),
      .next_best     (next_best),
      .next_best_idx (next_best_idx)
   );

   // FSM, scan counter, running top-2 and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         done_q    <= 1'b0;
         wait_low  <= 1'b1;
         best      <= '0;
         best_idx  <= '0;
         digit     <= '0;
         max_score <= '0;
         valid     <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
         second    <= '0;
         margin_q  <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         done_q <= done;
         if (!done) wait_low <= 1'b0;

         if (clear) begin
            state     <= IDLE;
            idx       <= '0;
            valid     <= 1'b0;
            digit     <= '0;
            max_score <= '0;
`ifdef ARGMAX_MARGIN_EN
            margin_q  <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= SCAN;
                     idx   <= '0;
                  end
               end
               SCAN: begin
                  best     <= next_best;
                  best_idx <= next_best_idx;
`ifdef ARGMAX_MARGIN_EN
                  second   <= next_second;
`endif
                  if (idx == LAST_IDX) begin
                     digit     <= next_best_idx;
                     max_score <= next_best;
`ifdef ARGMAX_MARGIN_EN
                     margin_q  <= {next_best[DATA_WIDTH-1], next_best}
                                - {next_second[DATA_WIDTH-1], next_second};
`endif
                     valid     <= 1'b1;
                     idx       <= '0;
                     state     <= HOLD;
                  end else begin
                     idx <= idx + IDX_WIDTH'(1);
                  end
               end
               HOLD: begin
                  if (start) begin
                     valid <= 1'b0;
                     idx   <= '0;
                     state <= SCAN;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dnn_argmax_seq.sv
// Directed bench for dnn_argmax_seq; expectations adapt to ARGMAX_MARGIN_EN.
module tb_dnn_argmax_seq;

   logic              clk = 1'b0;
   logic              rst;
   logic              done;
   logic              clear;
   logic [3:0]        out_idx;
   logic signed [7:0] score;
   logic [3:0]        digit;
   logic signed [7:0] max_score;
   logic [8:0]        margin;
   logic              busy;
   logic              valid;

   logic signed [7:0] scores [0:15];

   int errors = 0;
   int checks = 0;

`ifdef ARGMAX_MARGIN_EN
   localparam bit MEN = 1'b1;
`else
   localparam bit MEN = 1'b0;
`endif

   always #5 clk = ~clk;

   // Score source modelling the inference top's combinational select port.
   assign score = scores[out_idx];

   dnn_argmax_seq dut (
      .clk       (clk),
      .rst       (rst),
      .done      (done),
      .clear     (clear),
      .out_idx   (out_idx),
      .score     (score),
      .digit     (digit),
      .max_score (max_score),
      .margin    (margin),
      .busy      (busy),
      .valid     (valid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_scores(input int v [10]);
      for (int i = 0; i < 16; i++) scores[i] = (i < 10) ? 8'(v[i]) : 8'sd0;
   endtask

   // Pulse done, then count SCAN cycles until busy drops (bounded).
   task automatic run_scan(output int cyc);
      done = 1'b1;
      step();
      done = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; done = 1'b0; clear = 1'b0;
      load_scores('{0,0,0,0,0,0,0,0,0,0});
      step(); step();
      checks++; if (out_idx !== 4'd0)   begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
      checks++; if (digit !== 4'd0)     begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit); end
      checks++; if (max_score !== 8'sd0) begin errors++; $display("FAIL reset_max_score: got %0d expected 0", max_score); end
      checks++; if (margin !== 9'd0)    begin errors++; $display("FAIL reset_margin: got %0d expected 0", margin); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
      rst = 1'b0;
      step(); step();
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
   endtask

   task automatic test_tie();
      int c;
      load_scores('{-5,3,12,7,0,-128,11,2,12,1});
      run_scan(c);
      checks++; if (c != 10)             begin errors++; $display("FAIL tie_busy_cycles: got %0d expected 10", c); end
      checks++; if (valid !== 1'b1)      begin errors++; $display("FAIL tie_valid: got %0b expected 1", valid); end
      checks++; if (digit !== 4'd2)      begin errors++; $display("FAIL tie_digit: got %0d expected 2", digit); end
      checks++; if (max_score !== 8'sd12) begin errors++; $display("FAIL tie_max_score: got %0d expected 12", max_score); end
      checks++; if (margin !== 9'd0)     begin errors++; $display("FAIL tie_margin: got %0d expected 0", margin); end
      checks++; if (out_idx !== 4'd0)    begin errors++; $display("FAIL hold_out_idx: got %0d expected 0", out_idx); end
      step(); step();
      checks++; if (valid !== 1'b1 || digit !== 4'd2) begin errors++; $display("FAIL hold_stable: got valid=%0b digit=%0d expected 1/2", valid, digit); end
   endtask

   task automatic test_all_min();
      int c;
      load_scores('{-128,-128,-128,-128,-128,-128,-128,-128,-128,-128});
      run_scan(c);
      checks++; if (c != 10)                begin errors++; $display("FAIL min_busy_cycles: got %0d expected 10", c); end
      checks++; if (digit !== 4'd0)         begin errors++; $display("FAIL min_digit: got %0d expected 0", digit); end
      checks++; if (max_score !== 8'(-128)) begin errors++; $display("FAIL min_max_score: got %0d expected -128", max_score); end
      checks++; if (margin !== 9'd0)        begin errors++; $display("FAIL min_margin: got %0d expected 0", margin); end
   endtask

   task automatic test_last();
      int c;
      logic [8:0] exp_m;
      exp_m = MEN ? 9'd127 : 9'd0;
      load_scores('{0,0,0,0,0,0,0,0,0,127});
      run_scan(c);
      checks++; if (digit !== 4'd9)       begin errors++; $display("FAIL last_digit: got %0d expected 9", digit); end
      checks++; if (max_score !== 8'sd127) begin errors++; $display("FAIL last_max_score: got %0d expected 127", max_score); end
      checks++; if (margin !== exp_m)     begin errors++; $display("FAIL last_margin: got %0d expected %0d", margin, exp_m); end
   endtask

   task automatic test_hold_restart();
      int c;
      logic [8:0] exp_m;
      exp_m = MEN ? 9'd1 : 9'd0;
      load_scores('{10,20,-3,5,40,0,50,49,1,2});
      done = 1'b1;
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL restart_valid_drop: got %0b expected 0", valid); end
      checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL restart_busy: got %0b expected 1", busy); end
      done = 1'b0;
      c = 0;
      while (busy && c < 40) begin
         c++;
         step();
      end
      checks++; if (c != 10)             begin errors++; $display("FAIL restart_busy_cycles: got %0d expected 10", c); end
      checks++; if (valid !== 1'b1)      begin errors++; $display("FAIL restart_valid: got %0b expected 1", valid); end
      checks++; if (digit !== 4'd6)      begin errors++; $display("FAIL restart_digit: got %0d expected 6", digit); end
      checks++; if (max_score !== 8'sd50) begin errors++; $display("FAIL restart_max_score: got %0d expected 50", max_score); end
      checks++; if (margin !== exp_m)    begin errors++; $display("FAIL restart_margin: got %0d expected %0d", margin, exp_m); end
   endtask

   task automatic test_clear();
      int c;
      logic [8:0] exp_m;
      exp_m = MEN ? 9'd5 : 9'd0;
      load_scores('{1,9,4,0,0,0,0,0,0,0});
      done = 1'b1;
      step();
      done = 1'b0;
      repeat (4) step();
      checks++; if (out_idx !== 4'd4) begin errors++; $display("FAIL clear_pre_out_idx: got %0d expected 4", out_idx); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL clear_busy: got %0b expected 0", busy); end
      checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL clear_valid: got %0b expected 0", valid); end
      checks++; if (out_idx !== 4'd0)    begin errors++; $display("FAIL clear_out_idx: got %0d expected 0", out_idx); end
      checks++; if (digit !== 4'd0)      begin errors++; $display("FAIL clear_digit: got %0d expected 0", digit); end
      checks++; if (max_score !== 8'sd0) begin errors++; $display("FAIL clear_max_score: got %0d expected 0", max_score); end
      run_scan(c);
      checks++; if (c != 10)             begin errors++; $display("FAIL rescan_busy_cycles: got %0d expected 10", c); end
      checks++; if (digit !== 4'd1)      begin errors++; $display("FAIL rescan_digit: got %0d expected 1", digit); end
      checks++; if (max_score !== 8'sd9) begin errors++; $display("FAIL rescan_max_score: got %0d expected 9", max_score); end
      checks++; if (margin !== exp_m)    begin errors++; $display("FAIL rescan_margin: got %0d expected %0d", margin, exp_m); end
      // clear and a start edge in the same cycle: clear wins
      done = 1'b1; clear = 1'b1;
      step();
      clear = 1'b0;
      checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL clear_prio: got busy=%0b valid=%0b expected 0/0", busy, valid); end
      checks++; if (digit !== 4'd0)      begin errors++; $display("FAIL clear_prio_digit: got %0d expected 0", digit); end
      step();
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL clear_no_restart: got %0b expected 0", busy); end
      done = 1'b0;
      step();
   endtask

   task automatic test_rst_mid_scan();
      int c;
      load_scores('{-5,3,12,7,0,-128,11,2,12,1});
      done = 1'b1;
      step();
      repeat (3) step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %0b expected 1", busy); end
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || valid !== 1'b0 || out_idx !== 4'd0) begin errors++; $display("FAIL rst_async: got busy=%0b valid=%0b out_idx=%0d expected 0/0/0", busy, valid, out_idx); end
      step();
      rst = 1'b0;
      repeat (4) step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_done_high_no_start: got %0b expected 0", busy); end
      done = 1'b0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_done_low_idle: got %0b expected 0", busy); end
      run_scan(c);
      checks++; if (c != 10)        begin errors++; $display("FAIL rst_rescan_cycles: got %0d expected 10", c); end
      checks++; if (digit !== 4'd2 || valid !== 1'b1) begin errors++; $display("FAIL rst_rescan_digit: got digit=%0d valid=%0b expected 2/1", digit, valid); end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_all_min();
      test_last();
      test_hold_restart();
      test_clear();
      test_rst_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
